multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Multi-cycle control FSM for the RV32I-subset core: lw, sw, R-type, I-type ALU and beq. It sequences a shared-memory datapath through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select, and handshakes with a single-port instruction/data memory through memReq/memReady. A bounded-wait watchdog catches a memory that never responds. Illegal opcodes and memory timeouts put the block into a sticky fault state.

Parameters:
WAIT_MAX, 15, number of consecutive memReady-low cycles tolerated in one memory state before a fault is raised (1..2^CNT_W-1).
CNT_W, 4, width of the wait counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
op  input  7  opcode from the instruction register
zero  input  1  ALU zero flag
memReady  input  1  memory completion handshake; a read or write completes on the clk edge where memReq=1 and memReady=1
memReq  output  1  memory access request
memWrite  output  1  write qualifier, valid while memReq=1
adrSrc  output  1  memory address select: 0=PC, 1=ALU result register
irWrite  output  1  instruction register load enable
pcWrite  output  1  PC load enable
regWrite  output  1  register file write enable
resultSrc  output  2  result mux select: 00=ALU result register, 01=memory data register, 10=ALU output
aluSrcA  output  2  ALU A select: 00=PC, 01=oldPC, 10=rs1
aluSrcB  output  2  ALU B select: 00=rs2, 01=immediate, 10=constant 4
aluOp  output  2  to the ALU decoder: 00=add, 01=subtract, 10=use funct fields
immSrc  output  2  immediate format select
retire  output  1  one-cycle pulse when an instruction completes
fault  output  1  sticky error flag
state  output  4  current state encoding, for debug

Behaviour:
- Reset is asynchronous. While rst_n=0: state=FETCH, wait counter=0, fault=0. All outputs are Moore functions of state (plus gating noted below), so after reset they take FETCH values.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWRITE=4, MEMWB=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, FAULT=15.
- immSrc is combinational from op in every state: sw(0100011)=01, beq(1100011)=10, otherwise 00.
- Unless listed below, every output in a state is 0.
- FETCH: memReq=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10. irWrite=pcWrite=memReady. Stays in FETCH while memReady=0; goes to DECODE on memReady=1.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - any other value -> FAULT
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Next state is MEMREAD if op is lw, else MEMWRITE.
- MEMREAD: memReq=1, adrSrc=1. Waits for memReady, then -> MEMWB.
- MEMWRITE: memReq=1, memWrite=1, adrSrc=1. Waits for memReady, then -> FETCH with retire=1.
- MEMWB: resultSrc=01, regWrite=1. -> FETCH, retire=1.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp=10. -> ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp=10. -> ALUWB.
- ALUWB: resultSrc=00, regWrite=1. -> FETCH, retire=1.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, pcWrite=zero. -> FETCH, retire=1.
- FAULT: fault=1, all strobes 0. Exited only by reset.
- Latency with memReady always 1: R/I-type 4 cycles, lw 5, sw 4, beq 3.
- Wait counter:
  - Cleared on entry to any state.
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with memReady=0.
  - When the counter equals WAIT_MAX and memReady=0 -> FAULT. No strobe fires on that cycle.
  - memReady=1 on the cycle the counter reaches WAIT_MAX still completes normally (the response wins).
  - The counter saturates and never wraps.
- memReady outside memory states is ignored.
- Reset asserted mid-instruction, including mid-MEMWRITE, drops memWrite and memReq in the same cycle (asynchronously). No partial retire is reported.

Test Plan:
- Reset, then R-type op=0110011 with memReady=1 -> states 0,1,6,8,0. regWrite=1 only in ALUWB. retire pulses once, on cycle 4.
- lw op=0000011 with memReady held low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,5,0. memReq stays 1 through MEMREAD. No fault.
- beq with zero=1, then again with zero=0 -> pcWrite=1 in BEQ only for zero=1. Both take 3 cycles. immSrc=10 throughout.
- Illegal op=1111111 -> FETCH, DECODE, FAULT. fault=1 and stays there. All strobes remain 0 until rst_n is pulsed low.
- WAIT_MAX=15, memReady=0 forever in FETCH -> FAULT entered after 15 wait cycles. memReady=1 arriving on the 15th cycle instead -> normal transition to DECODE.
- sw stalled in MEMWRITE, then rst_n pulsed low -> memWrite=0 immediately, state=0. The next fetch proceeds normally.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle FSM and its datapath + memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic       zero;
  logic       memReady;
  logic       memReq;
  logic       memWrite;
  logic       adrSrc;
  logic       irWrite;
  logic       pcWrite;
  logic       regWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] immSrc;
  logic       retire;
  logic       fault;
  logic [3:0] state;

  modport master (
    input  op, zero, memReady,
    output memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, aluOp, immSrc, retire, fault, state
  );

  modport slave (
    output op, zero, memReady,
    input  memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, aluOp, immSrc, retire, fault, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset control FSM: 1-cycle-per-state sequencing, memory states stall on memReady.
// Bounded memory wait (WAIT_MAX low cycles tolerated); illegal opcode or timeout -> sticky FAULT.
module multicycle_controller #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       fault;
    logic       in_fetch;
    logic       in_beq;
    logic       in_memwr;
  } ctl_t;

  // Moore output table; handshake-dependent strobes are gated outside the register.
  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.in_fetch = 1'b1; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; c.in_memwr = 1'b1; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; c.retire = 1'b1; end
      S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    begin c.reg_write = 1'b1; c.retire = 1'b1; end
      S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.in_beq = 1'b1; c.retire = 1'b1; end
      S_FAULT:    c.fault = 1'b1;
      default:    c.fault = 1'b1;
    endcase
    return c;
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  ctl_t             r_ctl;
  logic             w_wait_state;
  logic             w_timeout;

  always_comb begin
    w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    // A response on the limit cycle still wins over the timeout.
    w_timeout    = w_wait_state && !bus.memReady && (r_cnt == CNT_W'(WAIT_MAX));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (bus.memReady) w_next = S_DECODE; else if (w_timeout) w_next = S_FAULT;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_FAULT;
        endcase
      end
      S_MEMADR:   w_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.memReady) w_next = S_MEMWB; else if (w_timeout) w_next = S_FAULT;
      S_MEMWRITE: if (bus.memReady) w_next = S_FETCH; else if (w_timeout) w_next = S_FAULT;
      S_MEMWB, S_ALUWB, S_BEQ: w_next = S_FETCH;
      S_EXECR, S_EXECI:        w_next = S_ALUWB;
      S_FAULT:    w_next = S_FAULT;
      default:    w_next = S_FAULT;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_next != r_state)
      w_cnt_next = '0;
    else if (w_wait_state && !bus.memReady && (r_cnt != {CNT_W{1'b1}}))
      w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_ctl   <= ctl_for(S_FETCH);
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ctl   <= ctl_for(w_next);
    end
  end

  // memReq is masked by reset so an in-flight access is withdrawn immediately.
  assign bus.memReq    = r_ctl.mem_req & rst_n;
  assign bus.memWrite  = r_ctl.mem_write;
  assign bus.adrSrc    = r_ctl.adr_src;
  assign bus.irWrite   = r_ctl.in_fetch & bus.memReady;
  assign bus.pcWrite   = (r_ctl.in_fetch & bus.memReady) | (r_ctl.in_beq & bus.zero);
  assign bus.regWrite  = r_ctl.reg_write;
  assign bus.resultSrc = r_ctl.result_src;
  assign bus.aluSrcA   = r_ctl.alu_src_a;
  assign bus.aluSrcB   = r_ctl.alu_src_b;
  assign bus.aluOp     = r_ctl.alu_op;
  assign bus.immSrc    = (bus.op == OP_SW) ? 2'b01 : (bus.op == OP_BEQ) ? 2'b10 : 2'b00;
  assign bus.retire    = r_ctl.retire | (r_ctl.in_memwr & bus.memReady);
  assign bus.fault     = r_ctl.fault;
  assign bus.state     = r_state;

endmodule
